// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// Holds the FSM state encoding, byte-lane constants and error-cause codes.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int LANE_W = 2;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;

  // Byte accesses touch one lane; word accesses touch all four.
  function automatic logic [3:0] lane_mask(input logic is_byte, input logic [LANE_W-1:0] lane);
    if (is_byte) return 4'b0001 << lane;
    else         return 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with per-lane write enables, asynchronous read and
// synchronous write. Contents are deliberately left unreset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic [3:0]    we_lane,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  assign rdata = mem_q[addr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we_lane[i]) mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Req/ack data-memory responder with programmable wait states, word/byte
// accesses and an error response for out-of-range or misaligned requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ack,
  output logic        err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] rd_q, rd_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;

  logic [1:0]  cause;
  logic        commit;
  logic [3:0]  we_lane;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  lane_byte;

  // Error check works on the latched request fields only.
  always_comb begin
    cause = ERR_NONE;
    if ({2'b00, a_q[31:2]} >= 32'(DEPTH))  cause = ERR_RANGE;
    else if (!byte_q && (a_q[1:0] != 2'b00)) cause = ERR_ALIGN;
  end

  // The access (read sample and write commit) happens on the edge leaving RESP.
  assign commit    = (state_q == ST_RESP) && we_q && (cause == ERR_NONE);
  assign we_lane   = commit ? lane_mask(byte_q, a_q[LANE_W-1:0]) : 4'b0000;
  assign wdata     = byte_q ? {4{wd_q[7:0]}} : wd_q;
  assign lane_byte = rdata[{a_q[1:0], 3'b000} +: 8];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .we_lane (we_lane),
    .addr    (a_q[AW+1:2]),
    .wdata   (wdata),
    .rdata   (rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    we_d    = we_q;
    byte_d  = byte_q;
    wd_d    = wd_q;
    rd_d    = rd_q;
    err_d   = err_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          a_d    = a;
          we_d   = we;
          byte_d = byte_op;
          wd_d   = wd;
          if (WAIT == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
        if (cause != ERR_NONE) begin
          err_d = 1'b1;
          rd_d  = 32'h0;
        end else begin
          err_d = 1'b0;
          if (we_q)        rd_d = 32'h0;
          else if (byte_q) rd_d = {24'h0, lane_byte};
          else             rd_d = rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      a_q     <= 32'h0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign rd        = rd_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT=2 for the
// functional scenarios and one with WAIT=0 for back-to-back requests.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req = 1'b0, we = 1'b0, byte_op = 1'b0;
  logic [31:0] a = '0, wd = '0;
  logic [31:0] rd;
  logic        ack, err;
  logic [1:0]  dbg_state;

  logic        req0 = 1'b0, we0 = 1'b0, byte0 = 1'b0;
  logic [31:0] a0 = '0, wd0 = '0;
  logic [31:0] rd0;
  logic        ack0, err0;
  logic [1:0]  dbg_state0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .byte_op(byte_op),
    .a(a), .wd(wd), .rd(rd), .ack(ack), .err(err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DEPTH(64), .WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .byte_op(byte0),
    .a(a0), .wd(wd0), .rd(rd0), .ack(ack0), .err(err0), .dbg_state(dbg_state0)
  );

  // Driver: issue one request on u_dut, hold it until ack, report response,
  // latency in cycles after capture, and ack one cycle later.
  // Called and returns at posedge+1 with the DUT idle.
  task automatic do_req(input logic w, input logic b, input logic [31:0] addr,
                        input logic [31:0] data, output logic [31:0] r,
                        output logic e, output int lat, output logic ack_next);
    req = 1'b1; we = w; byte_op = b; a = addr; wd = data;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 16 && ack !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    r = rd;
    e = err;
    @(posedge clk); #1;
    ack_next = ack;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=00000000", rd); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    checks++; if (ack0 !== 1'b0 || rd0 !== 32'h0) begin failures++; $display("FAIL reset_dut0 got=%b/%h exp=0/00000000", ack0, rd0); end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] r; logic e; int lat; logic an;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, r, e, lat, an);
    checks++; if (lat !== 3) begin failures++; $display("FAIL word_store_lat got=%0d exp=3", lat); end
    checks++; if (r !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL word_store_resp got=%h/%b exp=00000000/0", r, e); end
    checks++; if (an !== 1'b0) begin failures++; $display("FAIL word_store_ack_pulse got=%b exp=0", an); end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, r, e, lat, an);
    checks++; if (lat !== 3) begin failures++; $display("FAIL word_load_lat got=%0d exp=3", lat); end
    checks++; if (r !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_rd got=%h exp=deadbeef", r); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL word_load_err got=%b exp=0", e); end
    // Outputs hold while idle.
    repeat (2) @(posedge clk); #1;
    checks++; if (rd !== 32'hDEADBEEF || ack !== 1'b0) begin failures++; $display("FAIL idle_hold got=%h/%b exp=deadbeef/0", rd, ack); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r; logic e; int lat; logic an;
    do_req(1'b1, 1'b0, 32'h14, 32'h11223344, r, e, lat, an);
    do_req(1'b1, 1'b1, 32'h16, 32'h123456AA, r, e, lat, an);
    checks++; if (r !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL byte_store_resp got=%h/%b exp=00000000/0", r, e); end
    do_req(1'b0, 1'b1, 32'h16, 32'h0, r, e, lat, an);
    checks++; if (r !== 32'h000000AA || e !== 1'b0) begin failures++; $display("FAIL byte_load_16 got=%h/%b exp=000000aa/0", r, e); end
    do_req(1'b0, 1'b0, 32'h14, 32'h0, r, e, lat, an);
    checks++; if (r !== 32'h11AA3344) begin failures++; $display("FAIL word_after_byte got=%h exp=11aa3344", r); end
    do_req(1'b0, 1'b1, 32'h14, 32'h0, r, e, lat, an);
    checks++; if (r !== 32'h00000044) begin failures++; $display("FAIL byte_load_14 got=%h exp=00000044", r); end
    do_req(1'b0, 1'b1, 32'h17, 32'h0, r, e, lat, an);
    checks++; if (r !== 32'h00000011) begin failures++; $display("FAIL byte_load_17 got=%h exp=00000011", r); end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int lat; logic an;
    do_req(1'b1, 1'b0, 32'h0, 32'h0BADF00D, r, e, lat, an);
    do_req(1'b0, 1'b0, 32'h13, 32'h0, r, e, lat, an);
    checks++; if (lat !== 3) begin failures++; $display("FAIL misalign_lat got=%0d exp=3", lat); end
    checks++; if (e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL misalign_resp got=%h/%b exp=00000000/1", r, e); end
    do_req(1'b1, 1'b0, 32'd256, 32'hFFFFFFFF, r, e, lat, an);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin failures++; $display("FAIL range_store_resp got=%h/%b exp=00000000/1", r, e); end
    do_req(1'b1, 1'b0, 32'h2, 32'hFFFFFFFF, r, e, lat, an);
    checks++; if (e !== 1'b1) begin failures++; $display("FAIL misalign_store_err got=%b exp=1", e); end
    do_req(1'b0, 1'b0, 32'h0, 32'h0, r, e, lat, an);
    checks++; if (r !== 32'h0BADF00D || e !== 1'b0) begin failures++; $display("FAIL word0_unchanged got=%h/%b exp=0badf00d/0", r, e); end
    do_req(1'b0, 1'b1, 32'h3, 32'h0, r, e, lat, an);
    checks++; if (r !== 32'h0000000B || e !== 1'b0) begin failures++; $display("FAIL byte_unaligned_ok got=%h/%b exp=0000000b/0", r, e); end
  endtask

  task automatic test_back_to_back();
    logic        t_we [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] t_a  [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] t_wd [6] = '{32'hCAFE0000, 32'h0000BEEF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_rd [6] = '{32'h0, 32'h0, 32'hCAFE0000, 32'h0000BEEF, 32'hCAFE0000, 32'h0000BEEF};
    req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      we0 = t_we[i]; byte0 = 1'b0; a0 = t_a[i]; wd0 = t_wd[i];
      @(posedge clk); #1;
      checks++; if (ack0 !== 1'b0 || dbg_state0 !== 2'd2) begin failures++; $display("FAIL b2b_resp_cycle_%0d got=%b/%0d exp=0/2", i, ack0, dbg_state0); end
      @(posedge clk); #1;
      checks++; if (ack0 !== 1'b1 || rd0 !== t_rd[i] || err0 !== 1'b0) begin
        failures++; $display("FAIL b2b_ack_%0d got=%b/%h/%b exp=1/%h/0", i, ack0, rd0, err0, t_rd[i]);
      end
    end
    req0 = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b0 || dbg_state0 !== 2'd0) begin failures++; $display("FAIL b2b_idle got=%b/%0d exp=0/0", ack0, dbg_state0); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r; logic e; int lat; logic an; logic seen;
    do_req(1'b1, 1'b0, 32'h20, 32'h0, r, e, lat, an);
    do_req(1'b0, 1'b0, 32'h14, 32'h0, r, e, lat, an);
    req = 1'b1; we = 1'b1; byte_op = 1'b0; a = 32'h20; wd = 32'h55;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL abort_in_wait got=%0d exp=1", dbg_state); end
    reset = 1'b0;
    #1;
    checks++; if (ack !== 1'b0 || rd !== 32'h0 || err !== 1'b0 || dbg_state !== 2'd0) begin
      failures++; $display("FAIL abort_reset_outs got=%b/%h/%b/%0d exp=0/00000000/0/0", ack, rd, err, dbg_state);
    end
    @(negedge clk) reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", seen); end
    do_req(1'b0, 1'b0, 32'h20, 32'h0, r, e, lat, an);
    checks++; if (lat !== 3 || r !== 32'h0 || e !== 1'b0) begin failures++; $display("FAIL abort_no_write got=%0d/%h/%b exp=3/00000000/0", lat, r, e); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
